// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// soft-clear sequencer states and the packed read-port slice helper.
package regfile_pkg;

  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // LSB position of port k inside a packed bus of w-bit fields
  function automatic int rd_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Soft-clear sequencer: after a clr_req pulse in IDLE, walks every register
// address once (DEPTH cycles, one per clock); clr_req is ignored while busy.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  clr_state_t    state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(DEPTH - 1)) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins), NUM_RD zero-latency
// read ports, pending scoreboard, soft clear. REGFILE_BYPASS_EN adds write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AW       = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we0,
  input  logic [AW-1:0]        waddr0,
  input  logic [DW-1:0]        wdata0,
  input  logic                 we1,
  input  logic [AW-1:0]        waddr1,
  input  logic [DW-1:0]        wdata1,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_RD*DW-1:0] rdata,
  output logic [NUM_RD-1:0]    rpend,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 clr_req,
  output logic                 clr_busy
);

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr0_ok, wr1_ok, iss_ok;
  logic [AW-1:0]    ra;

  regfile_clr_seq #(.DEPTH(DEPTH), .AW(AW)) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Qualified requests: dead while clearing, and address 0 is inert with ZERO_REG
  assign wr0_ok = we0 && !clr_busy && !((ZERO_REG != 0) && (waddr0 == '0));
  assign wr1_ok = we1 && !clr_busy && !((ZERO_REG != 0) && (waddr1 == '0));
  assign iss_ok = iss_valid && !clr_busy && !((ZERO_REG != 0) && (iss_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_we && (clr_addr == AW'(i))) begin
          mem[i]  <= '0;
          pend[i] <= 1'b0;
        end else begin
          if (wr1_ok && (waddr1 == AW'(i)))      mem[i] <= wdata1;
          else if (wr0_ok && (waddr0 == AW'(i))) mem[i] <= wdata0;
          // A new issue outranks a retiring write: the newer producer owns the register
          if (iss_ok && (iss_addr == AW'(i)))
            pend[i] <= 1'b1;
          else if ((wr1_ok && (waddr1 == AW'(i))) || (wr0_ok && (waddr0 == AW'(i))))
            pend[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    rpend = '0;
    ra    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = raddr[rd_lsb(k, AW) +: AW];
      rdata[rd_lsb(k, DW) +: DW] = mem[ra];
      rpend[k] = pend[ra];
`ifdef REGFILE_BYPASS_EN
      if (!rst && wr1_ok && (waddr1 == ra)) begin
        rdata[rd_lsb(k, DW) +: DW] = wdata1;
        rpend[k] = iss_ok && (iss_addr == ra);
      end else if (!rst && wr0_ok && (waddr0 == ra)) begin
        rdata[rd_lsb(k, DW) +: DW] = wdata0;
        rpend[k] = iss_ok && (iss_addr == ra);
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for ports/scoreboard, then
// hand sequences for soft clear, reset during clear and same-cycle read-after-write.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1, iss_valid, clr_req;
  logic [4:0]  waddr0, waddr1, iss_addr;
  logic [31:0] wdata0, wdata1;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rpend;
  logic        clr_busy;

  int checks = 0;
  int errors = 0;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata), .rpend(rpend),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  ep;
  } vec_t;

  function automatic vec_t mk(logic w0, logic [4:0] a0, logic [31:0] d0,
                              logic w1, logic [4:0] a1, logic [31:0] d1,
                              logic is, logic [4:0] ia, logic [4:0] r0, logic [4:0] r1,
                              logic [31:0] e0, logic [31:0] e1, logic [1:0] ep);
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
    v.iss = is; v.ia = ia; v.ra0 = r0; v.ra1 = r1;
    v.e0 = e0; v.e1 = e1; v.ep = ep;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    we0 = 0; waddr0 = 0; wdata0 = 0;
    we1 = 0; waddr1 = 0; wdata1 = 0;
    iss_valid = 0; iss_addr = 0; clr_req = 0;
  endtask

  task automatic fill_index();
    for (int i = 0; i < 32; i++) begin
      we0 = 1; waddr0 = 5'(i); wdata0 = 32'(i);
      tick();
    end
    idle_in();
  endtask

  task automatic check_all_zero(string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      raddr = {5'd0, 5'(i)};
      #1;
      if (rdata[31:0] !== 32'd0 || rpend[0] !== 1'b0) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  vec_t v [19];

  initial begin
    int n;
    v[0]  = mk(0,0,0,          0,0,0,          0,0,  0,5,  32'h0,        32'h0,        2'b00);
    v[1]  = mk(1,5,32'h12345678,0,0,0,         0,0,  1,2,  32'h0,        32'h0,        2'b00);
    v[2]  = mk(0,0,0,          0,0,0,          0,0,  5,0,  32'h12345678, 32'h0,        2'b00);
    v[3]  = mk(1,7,32'hAAAAAAAA,1,7,32'h55555555,0,0, 5,6, 32'h12345678, 32'h0,        2'b00);
    v[4]  = mk(1,0,32'hFFFFFFFF,0,0,0,         0,0,  7,1,  32'h55555555, 32'h0,        2'b00);
    v[5]  = mk(0,0,0,          0,0,0,          1,3,  0,7,  32'h0,        32'h55555555, 2'b00);
    v[6]  = mk(0,0,0,          0,0,0,          0,0,  3,0,  32'h0,        32'h0,        2'b01);
    v[7]  = mk(0,0,0,          1,3,32'h33,     0,0,  0,1,  32'h0,        32'h0,        2'b00);
    v[8]  = mk(0,0,0,          0,0,0,          0,0,  3,0,  32'h33,       32'h0,        2'b00);
    v[9]  = mk(1,3,32'h44,     0,0,0,          1,3,  0,5,  32'h0,        32'h12345678, 2'b00);
    v[10] = mk(0,0,0,          0,0,0,          0,0,  3,0,  32'h44,       32'h0,        2'b01);
    v[11] = mk(0,0,0,          0,0,0,          1,0,  0,3,  32'h0,        32'h44,       2'b10);
    v[12] = mk(0,0,0,          0,0,0,          0,0,  0,3,  32'h0,        32'h44,       2'b10);
    v[13] = mk(0,0,0,          1,0,32'hFFFFFFFF,0,0, 0,0,  32'h0,        32'h0,        2'b00);
    v[14] = mk(0,0,0,          0,0,0,          0,0,  0,0,  32'h0,        32'h0,        2'b00);
    v[15] = mk(1,10,32'hA,     1,11,32'hB,     0,0,  1,2,  32'h0,        32'h0,        2'b00);
    v[16] = mk(0,0,0,          0,0,0,          0,0,  10,11, 32'hA,       32'hB,        2'b00);
    v[17] = mk(0,0,0,          1,3,32'h55,     0,0,  10,5, 32'hA,        32'h12345678, 2'b00);
    v[18] = mk(0,0,0,          0,0,0,          0,0,  3,7,  32'h55,       32'h55555555, 2'b00);

    idle_in();
    raddr = {5'd7, 5'd5};
    rst = 1;
    #12;
    chk("reset clr_busy", 32'(clr_busy), 32'd0);
    chk("reset rdata", rdata[31:0] | rdata[63:32], 32'd0);
    chk("reset rpend", 32'(rpend), 32'd0);
    @(posedge clk);
    #2;
    rst = 0;
    tick();

    for (int i = 0; i < 19; i++) begin
      we0 = v[i].we0; waddr0 = v[i].wa0; wdata0 = v[i].wd0;
      we1 = v[i].we1; waddr1 = v[i].wa1; wdata1 = v[i].wd1;
      iss_valid = v[i].iss; iss_addr = v[i].ia;
      raddr = {v[i].ra1, v[i].ra0};
      #1;
      chk($sformatf("vec%0d rdata0", i), rdata[31:0], v[i].e0);
      chk($sformatf("vec%0d rdata1", i), rdata[63:32], v[i].e1);
      chk($sformatf("vec%0d rpend", i), 32'(rpend), 32'(v[i].ep));
      chk($sformatf("vec%0d clr_busy", i), 32'(clr_busy), 32'd0);
      tick();
    end
    idle_in();

    // Soft clear with writes, issue and a second clr_req attempted mid-sequence
    fill_index();
    iss_valid = 1; iss_addr = 4;
    tick();
    idle_in();
    raddr = {5'd0, 5'd4};
    #1;
    chk("pre-clear pend r4", 32'(rpend[0]), 32'd1);
    clr_req = 1;
    tick();
    clr_req = 0;
    chk("clr_busy after req", 32'(clr_busy), 32'd1);
    n = 0;
    while (clr_busy && n < 100) begin
      if (n == 5) begin
        we0 = 1; waddr0 = 2; wdata0 = 32'h99;
        we1 = 1; waddr1 = 1; wdata1 = 32'h77;
        iss_valid = 1; iss_addr = 2; clr_req = 1;
        raddr = {5'd1, 5'd20};
        #1;
        chk("mid-clear r20 live", rdata[31:0], 32'd20);
        chk("mid-clear r1 cleared", rdata[63:32], 32'd0);
      end else begin
        idle_in();
      end
      n++;
      tick();
    end
    idle_in();
    chk("clear busy cycles", 32'(n), 32'd32);
    check_all_zero("after clear all zero");

    // Reset aborts a running clear
    fill_index();
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int i = 0; i < 10; i++) tick();
    raddr = {5'd0, 5'd20};
    #1;
    chk("busy at clear cycle 10", 32'(clr_busy), 32'd1);
    chk("r20 intact at cycle 10", rdata[31:0], 32'd20);
    rst = 1;
    #1;
    chk("busy drops on rst", 32'(clr_busy), 32'd0);
    chk("r20 zero in rst", rdata[31:0], 32'd0);
    tick();
    rst = 0;
    tick();
    chk("busy after rst", 32'(clr_busy), 32'd0);
    check_all_zero("after rst all zero");

    // Same-cycle write and read of r9
    we1 = 1; waddr1 = 9; wdata1 = 32'h1111;
    tick();
    we1 = 1; waddr1 = 9; wdata1 = 32'hDEADBEEF;
    iss_valid = 0;
    raddr = {5'd9, 5'd0};
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same-cycle r9", rdata[63:32], 32'hDEADBEEF);
`else
    chk("same-cycle r9", rdata[63:32], 32'h1111);
`endif
    tick();
    idle_in();
    #1;
    chk("next-cycle r9", rdata[63:32], 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
